// File: rtl/rs232_tx_fifo.sv
// ---------------------------------------------------------------------------
// rs232_tx_fifo
//   Parametrised RS-232 transmitter with an internal FIFO. Application words
//   enter through a valid/ready handshake and are serialised as
//   start / DATA_BITS data (LSB first) / optional parity / STOP_BITS stop.
//   Queued words go out back-to-back with no idle gap between frames.
//
// Parameters:
//   CLK_REF    reference clock in MHz
//   BAUD_RATE  line rate in bit/s (bit period = CLK_REF*1e6/BAUD_RATE cycles)
//   DATA_BITS  data bits per frame (5..9)
//   PARITY     0 none, 1 odd, 2 even
//   STOP_BITS  1 or 2
//   FIFO_DEPTH FIFO entries, power of two, >= 2
//
// Ports:
//   clk_ref         reference clock
//   rst             synchronous reset, active high
//   i_tx_dat        word to queue
//   i_tx_valid      i_tx_dat valid
//   o_tx_ready      FIFO can accept a word (registered, not full)
//   i_tx_enable     permits a new frame to start (never stops one in flight)
//   o_tx_pin        serial line, idle high
//   o_tx_busy       frame in progress
//   o_tx_send_over  one-cycle pulse in the last stop cycle of a frame
//   o_fifo_level    number of queued words
// ---------------------------------------------------------------------------
module rs232_tx_fifo #(
  parameter int CLK_REF    = 100,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_ref,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          i_tx_dat,
  input  logic                          i_tx_valid,
  output logic                          o_tx_ready,
  input  logic                          i_tx_enable,
  output logic                          o_tx_pin,
  output logic                          o_tx_busy,
  output logic                          o_tx_send_over,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam int DIV      = (CLK_REF * 1000000) / BAUD_RATE;
  localparam int STOP_LEN = STOP_BITS * DIV;
  // Counter covers the longest single state, which is the stop period.
  localparam int CW       = $clog2(STOP_LEN + 1);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int LW       = AW + 1;
  localparam int BW       = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_LEN - 1);
  localparam logic [BW-1:0] IDX_ZERO  = {BW{1'b0}};
  localparam logic [BW-1:0] IDX_ONE   = {{(BW-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);
  localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0] LVL_ZERO  = {LW{1'b0}};
  localparam logic [LW-1:0] LVL_ONE   = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Parity bit for a data word: odd mode makes the total ones count odd,
  // even mode makes it even.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  // ---------------- FIFO ----------------
  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_r;
  logic [AW-1:0]        rd_ptr_r;
  logic [LW-1:0]        level_r;
  logic [LW-1:0]        level_nx;
  logic                 ready_r;
  logic                 push_s;
  logic                 pop_s;
  logic [DATA_BITS-1:0] head_s;

  assign push_s = i_tx_valid & ready_r;
  assign head_s = mem_r[rd_ptr_r];

  // Next FIFO occupancy; push and pop together cancel out.
  always_comb begin
    level_nx = level_r;
    case ({push_s, pop_s})
      2'b10:   level_nx = level_r + LVL_ONE;
      2'b01:   level_nx = level_r - LVL_ONE;
      default: level_nx = level_r;
    endcase
  end

  // Storage array write port; contents need no reset since the pointers
  // define which entries are valid.
  always_ff @(posedge clk_ref) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= i_tx_dat;
    end
  end

  // FIFO pointers, level and the registered not-full flag.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LVL_ZERO;
      ready_r  <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      level_r <= level_nx;
      // Ready follows the new level, so a pop while full frees a slot
      // only from the next cycle on.
      ready_r <= (level_nx != LVL_FULL);
    end
  end

  // ---------------- Frame FSM ----------------
  logic [2:0]           state_r, state_nx;
  logic [CW-1:0]        cnt_r, cnt_nx;
  logic [BW-1:0]        idx_r, idx_nx;
  logic [DATA_BITS-1:0] shift_r, shift_nx;
  logic                 par_r, par_nx;
  logic                 pin_r, pin_nx;
  logic                 busy_r, busy_nx;
  logic                 send_r, send_nx;
  logic                 can_start_s;

  assign can_start_s = (level_r != LVL_ZERO) && i_tx_enable;

  // State transitions, bit timing and FIFO pop decision.
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r + CNT_ONE;
    idx_nx   = idx_r;
    shift_nx = shift_r;
    par_nx   = par_r;
    pop_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_nx = CNT_ZERO;
        if (can_start_s) begin
          pop_s    = 1'b1;
          shift_nx = head_s;
          par_nx   = parity_bit(head_s);
          state_nx = ST_START;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_r == BIT_LAST) begin
          cnt_nx   = CNT_ZERO;
          idx_nx   = IDX_ZERO;
          state_nx = ST_DATA;
        end else begin
          state_nx = ST_START;
        end
      end
      ST_DATA: begin
        if (cnt_r == BIT_LAST) begin
          cnt_nx   = CNT_ZERO;
          shift_nx = {1'b0, shift_r[DATA_BITS-1:1]};
          if (idx_r == IDX_LAST) begin
            state_nx = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            idx_nx = idx_r + IDX_ONE;
          end
        end else begin
          state_nx = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (cnt_r == BIT_LAST) begin
          cnt_nx   = CNT_ZERO;
          state_nx = ST_STOP;
        end else begin
          state_nx = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (cnt_r == STOP_LAST) begin
          cnt_nx = CNT_ZERO;
          // Chain straight into the next frame when a word is waiting.
          if (can_start_s) begin
            pop_s    = 1'b1;
            shift_nx = head_s;
            par_nx   = parity_bit(head_s);
            state_nx = ST_START;
          end else begin
            state_nx = ST_IDLE;
          end
        end else begin
          state_nx = ST_STOP;
        end
      end
      default: begin
        cnt_nx   = CNT_ZERO;
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Output values for the upcoming state, so the registered outputs line
  // up with the state register rather than lagging it by a cycle.
  always_comb begin
    pin_nx  = 1'b1;
    busy_nx = (state_nx != ST_IDLE);
    send_nx = (state_nx == ST_STOP) && (cnt_nx == STOP_LAST);
    case (state_nx)
      ST_START:  pin_nx = 1'b0;
      ST_DATA:   pin_nx = shift_nx[0];
      ST_PARITY: pin_nx = par_nx;
      default:   pin_nx = 1'b1;
    endcase
  end

  // FSM state and registered line outputs.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      idx_r   <= IDX_ZERO;
      shift_r <= {DATA_BITS{1'b0}};
      par_r   <= 1'b0;
      pin_r   <= 1'b1;
      busy_r  <= 1'b0;
      send_r  <= 1'b0;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      idx_r   <= idx_nx;
      shift_r <= shift_nx;
      par_r   <= par_nx;
      pin_r   <= pin_nx;
      busy_r  <= busy_nx;
      send_r  <= send_nx;
    end
  end

  assign o_tx_ready     = ready_r;
  assign o_fifo_level   = level_r;
  assign o_tx_pin       = pin_r;
  assign o_tx_busy      = busy_r;
  assign o_tx_send_over = send_r;

endmodule

// File: tb/tb_rs232_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_rs232_tx_fifo
//   Drives rs232_tx_fifo (7 data bits, even parity, 2 stop bits, 4-deep
//   FIFO, bit period 8 cycles) with directed and random traffic. A reference
//   model holds the accepted words in a queue and the frame in flight as a
//   bit vector indexed by elapsed time; every output is compared each cycle.
// ---------------------------------------------------------------------------
module tb_rs232_tx_fifo;

  localparam int CLK_REF    = 1;
  localparam int BAUD_RATE  = 125000;
  localparam int DB         = 7;
  localparam int PAR        = 2;
  localparam int SB         = 2;
  localparam int DEPTH      = 4;
  localparam int DIV        = (CLK_REF * 1000000) / BAUD_RATE;
  localparam int NBITS      = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
  localparam int FLEN       = NBITS * DIV;
  localparam int LW         = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [DB-1:0] dat;
  logic          valid;
  logic          enable;
  logic          ready;
  logic          pin;
  logic          busy;
  logic          send_over;
  logic [LW-1:0] level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rs232_tx_fifo #(
    .CLK_REF(CLK_REF), .BAUD_RATE(BAUD_RATE), .DATA_BITS(DB),
    .PARITY(PAR), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_ref(clk), .rst(rst), .i_tx_dat(dat), .i_tx_valid(valid),
    .o_tx_ready(ready), .i_tx_enable(enable), .o_tx_pin(pin),
    .o_tx_busy(busy), .o_tx_send_over(send_over), .o_fifo_level(level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Whole frame as a bit list: start, data LSB first, parity, stop bits.
  function automatic logic [31:0] make_frame(input logic [DB-1:0] w);
    logic [31:0] f;
    int ones;
    f    = 32'hFFFF_FFFF;
    ones = $countones(w);
    f[0] = 1'b0;
    for (int i = 0; i < DB; i++) f[1+i] = w[i];
    if (PAR == 1) f[1+DB] = (ones % 2 == 0) ? 1'b1 : 1'b0;
    if (PAR == 2) f[1+DB] = (ones % 2 == 1) ? 1'b1 : 1'b0;
    return f;
  endfunction

  // Reference model state and predicted outputs.
  logic [DB-1:0] q[$];
  logic [31:0]   m_frame = 32'hFFFF_FFFF;
  bit            m_active = 1'b0;
  int            m_pos = 0;
  bit            m_valid = 1'b0;
  logic          m_pin, m_busy, m_send, m_ready;
  int            m_level;
  int            frames_done = 0;

  // Mid-cycle: compare outputs against the model, then advance the model
  // by the clock edge that follows, using the inputs that edge will sample.
  always @(negedge clk) begin
    bit ready_now;
    bit start_ok;
    if (m_valid) begin
      chk("pin",       {31'd0, pin},       {31'd0, m_pin});
      chk("busy",      {31'd0, busy},      {31'd0, m_busy});
      chk("send_over", {31'd0, send_over}, {31'd0, m_send});
      chk("ready",     {31'd0, ready},     {31'd0, m_ready});
      chk("level",     32'(level),         32'(m_level));
      if (m_send) frames_done++;
    end
    ready_now = (q.size() != DEPTH);
    if (rst) begin
      q.delete();
      m_active = 1'b0;
      m_pos    = 0;
    end else begin
      start_ok = (q.size() > 0) && enable;
      if (m_active && m_pos != FLEN - 1) begin
        m_pos++;
      end else if (start_ok) begin
        m_frame  = make_frame(q.pop_front());
        m_active = 1'b1;
        m_pos    = 0;
      end else begin
        m_active = 1'b0;
      end
      if (valid && ready_now) q.push_back(dat);
    end
    m_valid = 1'b1;
    m_pin   = m_active ? m_frame[m_pos / DIV] : 1'b1;
    m_busy  = m_active;
    m_send  = m_active && (m_pos == FLEN - 1);
    m_level = q.size();
    m_ready = (q.size() != DEPTH);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [DB-1:0] w);
    valid = 1'b1;
    dat   = w;
    step(1);
    valid = 1'b0;
  endtask

  initial begin
    int f0;
    rst    = 1'b1;
    valid  = 1'b0;
    dat    = '0;
    enable = 1'b1;
    step(3);
    rst = 1'b0;
    step(3);

    // Single word with known parity: data 1,1,1,0,0,0,0 then parity 1.
    push(7'h07);
    step(2);
    chk("latency_pin_low", {31'd0, pin}, 32'd0);
    step(FLEN + 10);
    chk("one_frame", 32'(frames_done), 32'd1);

    // Two words on consecutive cycles: back-to-back frames.
    push(7'($urandom));
    push(7'($urandom));
    step(2 * FLEN + 10);
    chk("two_frames", 32'(frames_done), 32'd3);

    // Enable low: fill the FIFO, two extra words are dropped.
    enable = 1'b0;
    for (int i = 0; i < 6; i++) push(7'($urandom));
    step(3);
    chk("full_level", 32'(level), 32'(DEPTH));
    chk("full_ready", {31'd0, ready}, 32'd0);
    enable = 1'b1;
    step(4 * FLEN + 10);
    chk("drain_four", 32'(frames_done), 32'd7);

    // Enable dropped mid-frame: frame finishes, next waits for enable.
    push(7'($urandom));
    push(7'($urandom));
    push(7'($urandom));
    step(30);
    enable = 1'b0;
    step(2 * FLEN);
    chk("hold_pin_idle", {31'd0, pin}, 32'd1);
    enable = 1'b1;
    step(1);
    chk("restart_pin_low", {31'd0, pin}, 32'd0);
    step(2 * FLEN + 10);

    // Reset during the data bits: frame aborted, no completion pulse.
    f0 = frames_done;
    push(7'($urandom));
    push(7'($urandom));
    step(2 + DIV + 2 * DIV);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst_pin", {31'd0, pin}, 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_no_frame", 32'(frames_done), 32'(f0));
    push(7'($urandom));
    step(FLEN + 10);
    chk("post_rst_frame", 32'(frames_done), 32'(f0 + 1));

    // Random traffic, mostly enabled.
    for (int i = 0; i < 1500; i++) begin
      valid  = ($urandom_range(0, 3) == 0);
      dat    = 7'($urandom);
      enable = ($urandom_range(0, 9) != 0);
      step(1);
    end
    valid  = 1'b0;
    enable = 1'b1;
    step((DEPTH + 1) * FLEN + 10);
    chk("drained_level", 32'(level), 32'd0);
    chk("drained_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs232_tx_fifo.md
Name: rs232_tx_fifo

Overview:
Parametrised RS-232 transmitter, successor to the fixed 8N1 single-byte transmitter. Adds configurable data width, parity and stop bits, plus an internal FIFO with a valid/ready write handshake, so frames go out back-to-back with no idle gap. Sits between the application data path and the UART TX pin; baud timing is derived internally from CLK_REF/BAUD_RATE.

Parameters:
CLK_REF, 100, reference clock frequency in MHz
BAUD_RATE, 115200, line baud rate in bit/s
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, parity mode: 0 none, 1 odd, 2 even
STOP_BITS, 1, stop bits per frame; legal values 1 or 2
FIFO_DEPTH, 16, FIFO entries; power of two, at least 2

Ports:
clk_ref  in  1  reference clock
rst  in  1  synchronous reset, active-high
i_tx_dat  in  DATA_BITS  word to transmit
i_tx_valid  in  1  i_tx_dat valid
o_tx_ready  out  1  FIFO can accept a word (not full)
i_tx_enable  in  1  allow a new frame to start; gates the start of a frame only, never an in-progress frame
o_tx_pin  out  1  serial line, idle high
o_tx_busy  out  1  frame in progress
o_tx_send_over  out  1  one-cycle pulse when a frame completes
o_fifo_level  out  $clog2(FIFO_DEPTH)+1  number of queued words

Behaviour:
- Reset values: o_tx_pin=1, o_tx_busy=0, o_tx_send_over=0, o_tx_ready=1, o_fifo_level=0. State is IDLE and the FIFO is emptied.
- Bit period: DIV = CLK_REF*1000000/BAUD_RATE, integer truncation (868 at defaults). Each bit holds for exactly DIV clk_ref cycles.
- Write handshake:
  - A word is accepted on a cycle with i_tx_valid=1 and o_tx_ready=1.
  - o_tx_ready = FIFO not full, registered. When the FIFO is full, a pop in the same cycle does not allow a push; ready rises the following cycle.
  - Words presented while ready=0 are dropped; the FIFO contents do not change.
- o_fifo_level updates one cycle after the push or pop. A simultaneous push and pop leaves the level unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: pin=1. If the FIFO is non-empty and i_tx_enable=1, pop the head into the shift register and go to START.
  - START: pin=0 for DIV cycles, then go to DATA.
  - DATA: LSB first, DATA_BITS bits of DIV cycles each. Then go to PARITY if PARITY!=0, else STOP.
  - PARITY: one bit. Odd mode: the total count of ones in data plus parity is odd. Even mode: that count is even.
  - STOP: pin=1 for STOP_BITS*DIV cycles. o_tx_send_over pulses in the last STOP cycle. On the next cycle:
    - FIFO non-empty and enable=1: pop and go directly to START, with no idle cycles.
    - Otherwise: go to IDLE.
- Latency: a word pushed at cycle N into an empty FIFO with the FSM idle and enable high makes o_tx_pin fall at cycle N+2.
- o_tx_busy is 1 from the first START cycle through the last STOP cycle. It stays high across back-to-back frames.
- Frame length is (1 + DATA_BITS + (PARITY!=0) + STOP_BITS)*DIV cycles.
- i_tx_enable low mid-frame: the current frame completes normally, and no further frame starts until enable returns high.
- Reset mid-frame: on the next cycle pin=1, busy=0, FIFO empty. No send_over pulse is issued for the aborted frame.
- Unused high bits of i_tx_dat do not exist; width is exactly DATA_BITS.

Test Plan:
- Defaults (8N1, DIV=868); push 0x55 once -> pin falls 2 cycles after the push; bit sequence 0,1,0,1,0,1,0,1,0,1, each 868 cycles; send_over pulses once at cycle 8680 of the frame; busy is low afterwards.
- PARITY=2, DATA_BITS=7; push 0x07 -> data 1,1,1,0,0,0,0, then parity bit 1, then stop. With PARITY=1 the parity bit is 0.
- STOP_BITS=2; push 0xA3 and 0x3C in consecutive cycles -> two frames of 11*868 cycles, with the second start bit immediately after the first frame's 1736-cycle stop; busy never drops; two send_over pulses.
- FIFO_DEPTH=4, enable=0; push 6 words -> ready goes low after the 4th accept, level=4, words 5-6 dropped. Raise enable -> exactly 4 frames sent, in order.
- Drop enable mid-frame -> the current frame finishes; pin stays 1 while the FIFO is non-empty; the next frame starts 1 cycle after enable rises.
- Assert rst during DATA -> next cycle pin=1, busy=0, level=0, no send_over; a new push afterwards transmits correctly.
